// File: rtl/load_store_unit.sv
// Multicycle data-memory access stage: one word/byte load or store over a
// ready-handshaked bus, with misalignment and timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] r_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StFinish} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic        byte_en_q, byte_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] r_data_q, r_data_d;
  logic [31:0] load_data;

  always_comb begin
    load_data = mem_rdata;
    if (byte_en_q) begin
      unique case (addr_q[1:0])
        2'd0:    load_data = {24'b0, mem_rdata[7:0]};
        2'd1:    load_data = {24'b0, mem_rdata[15:8]};
        2'd2:    load_data = {24'b0, mem_rdata[23:16]};
        default: load_data = {24'b0, mem_rdata[31:24]};
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    byte_en_d = byte_en_q;
    addr_d    = addr_q;
    w_data_d  = w_data_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    r_data_d  = r_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          is_load_d = is_load;
          byte_en_d = byte_en;
          addr_d    = addr;
          w_data_d  = w_data;
          cnt_d     = 8'd0;
          // Misaligned word access faults without touching the bus
          if (!byte_en && (addr[1:0] != 2'b00)) begin
            state_d = StFinish;
            fault_d = 1'b1;
          end else begin
            state_d = StAccess;
            fault_d = 1'b0;
          end
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_d = StFinish;
          fault_d = 1'b0;
          if (is_load_q) r_data_d = load_data;
        end else if (cnt_q == CntLast) begin
          state_d = StFinish;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_load_q <= 1'b0;
      byte_en_q <= 1'b0;
      addr_q    <= '0;
      w_data_q  <= '0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      byte_en_q <= byte_en_d;
      addr_q    <= addr_d;
      w_data_q  <= w_data_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      r_data_q  <= r_data_d;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StFinish);
    fault     = done & fault_q;
    r_data    = r_data_q;
    mem_req   = (state_q == StAccess);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = '0;
    if (mem_req) begin
      mem_we   = ~is_load_q;
      mem_addr = {addr_q[31:2], 2'b00};
      if (!is_load_q) begin
        if (byte_en_q) begin
          mem_wstrb = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{w_data_q[7:0]}};
        end else begin
          mem_wstrb = 4'b1111;
          mem_wdata = w_data_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: per-access latency, bus, fault
// and load-data checks, plus reset-mid-access sequence.
module tb_load_store_unit;

  localparam int unsigned T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, byte_en;
  logic [31:0] addr, w_data;
  logic        busy, done, fault;
  logic [31:0] r_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .byte_en   (byte_en),
    .addr      (addr),
    .w_data    (w_data),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .r_data    (r_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        be;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          wait_n;    // ready asserted in ACCESS cycle wait_n+1; 255 = never
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_r;
    logic        exp_fault;
    int          exp_done;  // cycle of done, start accepted at edge 0
    int          exp_req;   // number of cycles with mem_req high
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " busy"}, {31'b0, busy}, 32'd0);
    check({name, " done"}, {31'b0, done}, 32'd0);
    check({name, " fault"}, {31'b0, fault}, 32'd0);
    check({name, " r_data"}, r_data, 32'd0);
    check({name, " mem_req"}, {31'b0, mem_req}, 32'd0);
    check({name, " mem_we"}, {31'b0, mem_we}, 32'd0);
    check({name, " mem_addr"}, mem_addr, 32'd0);
    check({name, " mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
    check({name, " mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Called in an idle cycle; returns in the idle cycle after done.
  task automatic run_vec(input int idx, input vec_t v);
    int  req_cnt;
    int  done_cyc;
    bit  bus_ok;
    start   = 1'b1;
    is_load = v.ld;
    byte_en = v.be;
    addr    = v.a;
    w_data  = v.wd;
    tick();
    req_cnt  = 0;
    done_cyc = -1;
    bus_ok   = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      // A start during busy must be ignored
      if (cyc == 2) begin
        start   = 1'b1;
        is_load = ~v.ld;
        byte_en = 1'b0;
        addr    = 32'hFFFF_FFF0;
        w_data  = 32'h0BAD_0BAD;
      end else begin
        start = 1'b0;
      end
      mem_ready = (cyc == v.wait_n + 1);
      mem_rdata = mem_ready ? v.rd : 32'hBAD0_BAD0;
      #0;
      if (!busy) bus_ok = 1'b0;
      if (mem_req) begin
        req_cnt++;
        if (mem_addr !== v.exp_addr || mem_wstrb !== v.exp_strb || mem_we !== ~v.ld)
          bus_ok = 1'b0;
        if (!v.ld && mem_wdata !== v.exp_wdata) bus_ok = 1'b0;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    check($sformatf("v%0d done cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d req cycles", idx), req_cnt, v.exp_req);
    check($sformatf("v%0d bus stable/busy", idx), {31'b0, bus_ok}, 32'd1);
    check($sformatf("v%0d fault", idx), {31'b0, fault}, {31'b0, v.exp_fault});
    check($sformatf("v%0d r_data", idx), r_data, v.exp_r);
    start     = 1'b0;
    mem_ready = 1'b1;  // ignored outside ACCESS
    tick();
    check($sformatf("v%0d busy after done", idx), {31'b0, busy}, 32'd0);
    check($sformatf("v%0d done single", idx), {31'b0, done}, 32'd0);
  endtask

  initial begin
    //          ld    be    addr           wdata          rdata         wait
    //          exp_addr       strb     exp_wdata      exp_r          flt   done req
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 0,
                32'h0000_0104, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 2,  1};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 32'h0,         3,
                32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0, 5,  4};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0012, 32'h0,         32'h1122_3344, 1,
                32'h0000_0010, 4'b0000, 32'h0,         32'h0000_0022, 1'b0, 3,  2};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0002, 32'h1234_5678, 32'h0,         0,
                32'h0,         4'b0000, 32'h0,         32'h0000_0022, 1'b1, 1,  0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0,         0,
                32'h0000_0040, 4'b1111, 32'h1234_5678, 32'h0000_0022, 1'b0, 2,  1};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         32'h0,         255,
                32'h0000_0080, 4'b0000, 32'h0,         32'h0000_0022, 1'b1, 17, 16};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,         32'hCAFE_F00D, 15,
                32'h0000_0084, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0, 17, 16};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0,         32'hAB00_0000, 2,
                32'h0000_0004, 4'b0000, 32'h0,         32'h0000_00AB, 1'b0, 4,  3};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'h0,         0,
                32'h0,         4'b0000, 32'h0,         32'h0000_00AB, 1'b1, 1,  0};
    vecs[9] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_55AA, 0,
                32'h0000_0200, 4'b0000, 32'h0,         32'h0000_55AA, 1'b0, 2,  1};

    rst       = 1'b1;
    start     = 1'b0;
    is_load   = 1'b0;
    byte_en   = 1'b0;
    addr      = '0;
    w_data    = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset in the second ACCESS cycle of a never-ready load
    start     = 1'b1;
    is_load   = 1'b1;
    byte_en   = 1'b0;
    addr      = 32'h0000_0100;
    tick();
    start     = 1'b0;
    mem_ready = 1'b0;
    check("mid-reset req up", {31'b0, mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_outputs_zero("mid-reset");
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post-reset no done", {30'b0, done, busy}, 32'd0);
    end

    run_vec(9, vecs[9]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle data-memory access stage sitting directly downstream of the ALU in `cpu`. It takes the latched ALU result `F` as the effective address and the store operand from register port C. It performs one word or byte load/store over a ready-handshaked memory bus and returns load data for register write-back. The controller starts it with a one-cycle pulse and holds the datapath while `busy` is high.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum cycles `mem_req` may stay high waiting for `mem_ready` before the access is aborted; legal range 2..255.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle access request from the controller; sampled only in IDLE.
- `is_load` in 1: 1 = load, 0 = store; sampled with `start`.
- `byte_en` in 1: 1 = byte access, 0 = word access; sampled with `start`.
- `addr` in 32: effective address (ALU `F`); sampled with `start`.
- `w_data` in 32: store data (register C read); sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; 1 = misaligned word access or timeout.
- `r_data` out 32: load result; updated only by a successful load, otherwise held.
- `mem_req` out 1: bus request, held until accepted or aborted.
- `mem_we` out 1: write enable, valid while `mem_req` is high.
- `mem_addr` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_wstrb` out 4: byte-lane write strobes.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.
- `mem_ready` in 1: bus accept/complete for the current request.

## Operation
- States: IDLE, ACCESS, FINISH.
- IDLE with `start`=1: latch `is_load`, `byte_en`, `addr`, `w_data`.
  - Word access with `addr[1:0]`≠0: go to FINISH with fault, no bus request.
  - All other accesses: go to ACCESS.
- IDLE with `start`=0: stay in IDLE.
- ACCESS:
  - Drive `mem_req`=1 and `mem_we`=~is_load. Bus outputs stay constant throughout ACCESS.
  - When `mem_ready`=1, capture load data and go to FINISH with fault=0.
  - Wait counter (8-bit) clears on entry and increments each cycle `mem_ready` is 0.
  - If `mem_ready` is 0 in the TIMEOUT_CYCLES-th ACCESS cycle, go to FINISH with fault=1. `r_data` is unchanged.
- FINISH: assert `done`=1 for one cycle, then return to IDLE.
- Write strobes and data:
  - Word store: `mem_wstrb`=4'b1111, `mem_wdata`=w_data.
  - Byte store: `mem_wstrb`=4'b0001<<addr[1:0], `mem_wdata`={4{w_data[7:0]}}.
  - Loads: `mem_wstrb`=4'b0000.
- Load data:
  - Word load: `r_data`=mem_rdata.
  - Byte load: `r_data`={24'b0, lane addr[1:0] of mem_rdata}. Lane 0 = bits 7:0, little-endian.
- `start` while busy is ignored; there is no queueing.
- Bus outputs are zero whenever `mem_req`=0.

## Timing
- Reset values: all outputs 0 (`busy`, `done`, `fault`, `r_data`, `mem_req`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata`); state IDLE; counter 0.
- Reset mid-access: `mem_req` drops at the reset edge, no `done` is produced, and the latched request is discarded.
- Latency, with `start` accepted at edge 0:
  - `mem_req` and `busy` are high from cycle 1.
  - If `mem_ready` is high in cycle 1+k, `done` is high in cycle 2+k. The minimum `start`-to-`done` latency is 2 cycles.
- Misaligned word: `busy` and `done`/`fault` are all high in cycle 1; no bus activity.
- Timeout: `mem_req` is high for exactly TIMEOUT_CYCLES cycles; `done`/`fault` follow in the next cycle.
- `mem_ready` arriving in the last allowed cycle counts as success; success beats timeout.
- `r_data` changes on the same edge that raises `done` for a successful load.
- `busy` falls the cycle after `done`. A new `start` in that cycle is accepted, giving back-to-back accesses with one idle cycle.
- `mem_ready` is ignored outside ACCESS.

## Test plan
- Word load: addr=0x0000_0104, is_load=1, mem_ready in the first ACCESS cycle, mem_rdata=0xDEAD_BEEF -> mem_addr=0x104, mem_we=0; `done` 2 cycles after `start`; r_data=0xDEAD_BEEF; fault=0.
- Byte store: addr=0x0000_0203, w_data=0x0000_00A5, byte_en=1, mem_ready after 3 wait cycles -> mem_addr=0x200, mem_wstrb=4'b1000, mem_wdata=0xA5A5_A5A5 held stable for 4 cycles; `done` at cycle 5; fault=0.
- Byte load, lane 2: addr=0x0000_0012, mem_rdata=0x1122_3344 -> r_data=0x0000_0022.
- Misaligned word store: addr=0x0000_0002 -> mem_req never rises; `done`=`fault`=1 in cycle 1; r_data unchanged.
- Timeout: TIMEOUT_CYCLES=16, mem_ready held at 0 -> mem_req high for cycles 1–16; `done`/`fault` in cycle 17; a second `start` during busy is ignored. A repeat run with mem_ready in cycle 16 gives fault=0.
- Reset: rst asserted in the second ACCESS cycle -> all outputs 0 at the next edge; no `done`. A fresh `start` afterwards completes normally.
